// File: rtl/fifo_serial_tx_if.sv
// Bundle between the FIFO drain stage and its environment: FIFO read handshake,
// serial line and frame status.
interface fifo_serial_tx_if #(
    parameter int DATA_W = 17
);
    logic              enable;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_pull;
    logic              ser_out;
    logic              busy;
    logic              frame_done;

    modport master (
        input  enable, fifo_empty, fifo_data,
        output fifo_pull, ser_out, busy, frame_done
    );

    modport slave (
        output enable, fifo_empty, fifo_data,
        input  fifo_pull, ser_out, busy, frame_done
    );
endinterface

// File: rtl/fifo_serial_tx.sv
// FIFO drain stage: pulls one word at a time and sends it as start/data(LSB first)/stop.
// Define SERIAL_TX_PARITY_EN to add an even-parity bit between the data and the stop bit.
module fifo_serial_tx #(
    parameter int DATA_W  = 17,
    parameter int CLK_DIV = 4
) (
    input logic              clk,
    input logic              rst,
    fifo_serial_tx_if.master bus
);
    localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULL,
        S_CAPT,
        S_START,
        S_DATA,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              ser_q;
    logic              done_q;
    logic              div_wrap;
    logic              bit_last;
    logic              pull_c;
    logic              busy_c;

`ifdef SERIAL_TX_PARITY_EN
    logic par_q;

    function automatic logic even_parity(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction
`endif

    assign div_wrap = (div_cnt == DIV_LAST);
    assign bit_last = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.enable && !bus.fifo_empty) begin
                    state_nxt = S_PULL;
                end
            end
            S_PULL:  state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_START;
            S_START: begin
                if (div_wrap) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (div_wrap && bit_last) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_nxt = S_PARITY;
`else
                    state_nxt = S_STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (div_wrap) begin
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (div_wrap) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pull strobe is a pure state decode, so exactly one pulse per visit to PULL.
    always_comb begin
        pull_c = 1'b0;
        busy_c = 1'b1;
        case (state)
            S_IDLE:  busy_c = 1'b0;
            S_PULL:  pull_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.fifo_pull  = pull_c;
    assign bus.busy       = busy_c;
    assign bus.ser_out    = ser_q;
    assign bus.frame_done = done_q;

    // Line register and shifter: ser_q only moves at a divider wrap or on capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            ser_q   <= 1'b1;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_CAPT: begin
                    shreg   <= bus.fifo_data;
                    ser_q   <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_q   <= even_parity(bus.fifo_data);
`endif
                end
                S_START: begin
                    div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
                    if (div_wrap) begin
                        ser_q <= shreg[0];
                    end
                end
                S_DATA: begin
                    div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
                    if (div_wrap) begin
                        if (bit_last) begin
`ifdef SERIAL_TX_PARITY_EN
                            ser_q <= par_q;
`else
                            ser_q <= 1'b1;
`endif
                        end else begin
                            shreg   <= shreg >> 1;
                            ser_q   <= shreg[1];
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
                    if (div_wrap) begin
                        ser_q <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
                    if (div_wrap) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: small FIFO model, table of frames plus hand-written
// sequences for reset abort, back-to-back frames and enable gating.
module tb_fifo_serial_tx;
    localparam int DATA_W  = 17;
    localparam int CLK_DIV = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = DATA_W + 2 + P;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_serial_tx_if #(.DATA_W(DATA_W)) ifc();

    fifo_serial_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // FIFO model: registered output updates on the edge that ends the pull cycle.
    logic [DATA_W-1:0] mem [0:15];
    int                wr_ptr = 0;
    int                rd_ptr = 0;
    int                pulls  = 0;
    logic [DATA_W-1:0] fifo_q = '0;

    assign ifc.fifo_empty = (wr_ptr == rd_ptr);
    assign ifc.fifo_data  = fifo_q;

    always @(posedge clk) begin
        if (ifc.fifo_pull) begin
            if (rd_ptr != wr_ptr) begin
                fifo_q <= mem[rd_ptr[3:0]];
                rd_ptr <= rd_ptr + 1;
            end
            pulls <= pulls + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_pull(output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            seen = ifc.fifo_pull;
        end
    endtask

    // Entered at (or waits for) the negedge inside the PULL cycle; leaves at the
    // negedge of the first IDLE cycle.
    task automatic run_frame(input logic [DATA_W-1:0] word, input logic exp_par, input bit at_pull);
        logic [DATA_W-1:0] dec;
        bit                seen;
        bit                ok;
        logic              e;
        dec = '0;
        if (!at_pull) begin
            wait_pull(seen);
            chk("pull_seen", 32'(seen), 32'd1);
            if (!seen) return;
        end
        chk("pull_cycle_line", 32'({ifc.ser_out, ifc.busy}), 32'b11);
        @(negedge clk);
        chk("capt_cycle", 32'({ifc.fifo_pull, ifc.ser_out, ifc.busy}), 32'b011);
        for (int b = 0; b < NB; b++) begin
            if (b == 0) e = 1'b0;
            else if (b <= DATA_W) e = word[b-1];
            else if (P == 1 && b == DATA_W + 1) e = exp_par;
            else e = 1'b1;
            ok = 1'b1;
            for (int c = 0; c < CLK_DIV; c++) begin
                @(negedge clk);
                if (ifc.ser_out !== e || ifc.fifo_pull !== 1'b0 ||
                    ifc.frame_done !== 1'b0 || ifc.busy !== 1'b1) ok = 1'b0;
                if (c == CLK_DIV / 2 && b >= 1 && b <= DATA_W) dec[b-1] = ifc.ser_out;
            end
            chk($sformatf("line_bit%0d_ok", b), 32'(ok), 32'd1);
        end
        chk("decoded_word", 32'(dec), 32'(word));
        @(negedge clk);
        chk("frame_done_idle", 32'({ifc.frame_done, ifc.busy}), 32'b10);
    endtask

    typedef struct {
        logic [DATA_W-1:0] word;
        logic              par;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int p0;
        bit ok;
        bit seen;

        vecs[0] = '{17'h15A5A, 1'b1};
        vecs[1] = '{17'h00000, 1'b0};
        vecs[2] = '{17'h1FFFF, 1'b1};
        vecs[3] = '{17'h00001, 1'b1};
        vecs[4] = '{17'h0AAAA, 1'b0};

        ifc.enable = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'({ifc.ser_out, ifc.fifo_pull, ifc.busy, ifc.frame_done}), 32'b1000);
        rst = 1'b0;

        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (ifc.ser_out !== 1'b1 || ifc.fifo_pull !== 1'b0 || ifc.busy !== 1'b0) ok = 1'b0;
        end
        chk("idle_empty_50", 32'(ok), 32'd1);

        for (int i = 0; i < 5; i++) begin
            p0 = pulls;
            push(vecs[i].word);
            run_frame(vecs[i].word, vecs[i].par, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_pulls", i), 32'(pulls - p0), 32'd1);
        end

        // Three preloaded words, enable held: one IDLE cycle between frames.
        p0 = pulls;
        push(17'h00000);
        push(17'h1FFFF);
        push(17'h00001);
        run_frame(17'h00000, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_pull2", 32'(ifc.fifo_pull), 32'd1);
        run_frame(17'h1FFFF, 1'b1, 1'b1);
        @(negedge clk);
        chk("b2b_pull3", 32'(ifc.fifo_pull), 32'd1);
        run_frame(17'h00001, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        chk("b2b_end", 32'({ifc.busy, ifc.fifo_empty}), 32'b01);
        chk("b2b_pulls", 32'(pulls - p0), 32'd3);

        // Reset during data bit 5 aborts the frame; the word is not resent.
        p0 = pulls;
        push(17'h15A5A);
        wait_pull(seen);
        chk("abort_pull_seen", 32'(seen), 32'd1);
        repeat (27) @(negedge clk);
        chk("abort_bit5", 32'({ifc.ser_out, ifc.busy}), 32'b01);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_after_rst", 32'({ifc.ser_out, ifc.busy, ifc.fifo_pull, ifc.frame_done}), 32'b1000);
        rst = 1'b0;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (ifc.ser_out !== 1'b1 || ifc.busy !== 1'b0 || ifc.fifo_pull !== 1'b0) ok = 1'b0;
        end
        chk("abort_quiet", 32'(ok), 32'd1);
        chk("abort_pulls", 32'(pulls - p0), 32'd1);
        push(17'h0AAAA);
        run_frame(17'h0AAAA, 1'b0, 1'b0);

        // Enable gating: no pull while low, pull right after it is sampled high,
        // frame completes when enable drops mid-frame.
        @(negedge clk);
        ifc.enable = 1'b0;
        p0 = pulls;
        push(17'h15A5A);
        push(17'h00001);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ifc.fifo_pull !== 1'b0 || ifc.busy !== 1'b0) ok = 1'b0;
        end
        chk("en_low_no_pull", 32'(ok), 32'd1);
        ifc.enable = 1'b1;
        @(negedge clk);
        chk("en_pull_next", 32'(ifc.fifo_pull), 32'd1);
        fork
            begin
                repeat (10) @(negedge clk);
                ifc.enable = 1'b0;
            end
        join_none
        run_frame(17'h15A5A, 1'b1, 1'b1);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ifc.fifo_pull !== 1'b0 || ifc.busy !== 1'b0) ok = 1'b0;
        end
        chk("en_drop_idle", 32'(ok), 32'd1);
        chk("en_pulls", 32'(pulls - p0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
